// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit serializer and the receiver:
// FSM state type, frame geometry and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS        = 8;
    localparam int UART_DEF_CLKS_PER_BIT = 5208;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer. Counts sysclk cycles while enabled and raises bitTick for
// one cycle at terminal count (CLKS_PER_BIT-1), then wraps to 0. clear forces
// the count back to 0 so each frame starts from a fresh bit boundary.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bitTick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("CLKS_PER_BIT must be in 4..65535");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and wrap at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bitTick = enable && !clear && (cnt_q == TERM);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter, 8 data bits LSB first, 1 or 2 stop bits.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is
// defined; without it the frame is plain 8N1/8N2 and no parity logic exists.
//
// Handshake: a byte is accepted on a rising edge where txValid && txReady.
// txReady is high only in IDLE; txValid must be held until accepted, and
// txValid seen while the frame is in flight is ignored (nothing is queued).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       serialOut,
    output logic       txBusy,
    output logic       txDone,
    output tx_state_t  dbg_state
);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      stop_cnt_q, stop_cnt_d;
    logic                      serial_q, serial_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    logic accept;
    logic bit_tick;

    assign accept = txValid && ready_q;

    // The counter restarts on every accept, so bit edges line up with the frame.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (accept),
        .enable (state_q != IDLE),
        .bitTick(bit_tick)
    );

    // Next-state and next line level; the line is computed one cycle ahead so serialOut is a flop.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        serial_d   = serial_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = accept ? ^txData : parity_q;
`endif
        case (state_q)
            IDLE: begin
                serial_d = UART_IDLE;
                if (accept) begin
                    shreg_d    = txData;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = START;
                    serial_d   = UART_START;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d  = DATA;
                    serial_d = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        serial_d = parity_q;
`else
                        state_d  = STOP;
                        serial_d = UART_IDLE;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                        serial_d  = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d  = STOP;
                    serial_d = UART_IDLE;
                end
            end
`endif
            STOP: begin
                serial_d = UART_IDLE;
                if (bit_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = UART_IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // FSM and registered outputs; reset parks the line high immediately.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            serial_q   <= UART_IDLE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            serial_q   <= serial_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign serialOut = serial_q;
    assign txReady   = ready_q;
    assign txBusy    = busy_q;
    assign txDone    = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer with CLKS_PER_BIT=16, STOP_BITS=1.
// Expected line levels come from the frame rule (start 0, data LSB first,
// optional even parity, stop 1s), each bit held CPB cycles.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int STOPS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_BITS = 10 + STOPS - 1 + PAR;
    localparam int FRAME_CYC  = FRAME_BITS * CPB;

    logic       sysclk;
    logic       reset;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       serialOut;
    logic       txBusy;
    logic       txDone;
    tx_state_t  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    uart_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (STOPS)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .txData   (txData),
        .txValid  (txValid),
        .txReady  (txReady),
        .serialOut(serialOut),
        .txBusy   (txBusy),
        .txDone   (txDone),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Level of frame bit i for byte d.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (PAR == 1 && i == 9) return ^d;
        return 1'b1;
    endfunction

    // Wait for txReady, present the byte, return #1 after the accept edge.
    task automatic accept_byte(input logic [7:0] d, input logic hold);
        int waited = 0;
        @(negedge sysclk);
        while (!txReady && waited < 400) begin
            @(negedge sysclk);
            waited++;
        end
        if (!txReady) check_eq("ready_timeout", txReady, 1);
        txData  = d;
        txValid = 1'b1;
        @(posedge sysclk);
        #1;
        check_eq("accept_busy", txBusy, 1);
        if (!hold) begin
            txValid = 1'b0;
            txData  = 8'($urandom);
        end
    endtask

    // Checks every cycle of the frame that started at the last accept edge.
    // inject_at: cycle to pulse txValid with 0xFF. abort_at: cycle to assert reset.
    task automatic check_frame(input logic [7:0] d, input int inject_at, input int abort_at);
        logic [7:0] rx = 8'h00;
        int bi;
        exp_q.push_back(d);
        for (int k = 1; k <= FRAME_CYC; k++) begin
            @(negedge sysclk);
            bi = (k - 1) / CPB;
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                check_eq("abort_line", serialOut, 1);
                check_eq("abort_busy", txBusy, 0);
                check_eq("abort_ready", txReady, 0);
                check_eq("abort_done", txDone, 0);
                void'(exp_q.pop_back());
                return;
            end
            if (!txValid) txData = 8'($urandom);
            if (inject_at != 0 && k == inject_at) begin
                txValid = 1'b1;
                txData  = 8'hFF;
            end else if (inject_at != 0 && k == inject_at + 1) begin
                txValid = 1'b0;
            end
            check_eq("line", serialOut, exp_bit(d, bi));
            check_eq("busy", txBusy, 1);
            check_eq("ready_busy", txReady, 0);
            check_eq("done_early", txDone, 0);
            if ((k - 1) % CPB == CPB / 2 && bi >= 1 && bi <= 8) rx[bi-1] = serialOut;
        end
        @(negedge sysclk);
        check_eq("done_pulse", txDone, 1);
        check_eq("end_busy", txBusy, 0);
        check_eq("end_ready", txReady, 1);
        check_eq("idle_line", serialOut, 1);
        check_eq("rx_byte", rx, exp_q.pop_front());
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        accept_byte(a, 1'b1);
        txData = b;
        check_frame(a, 0, 0);
        @(posedge sysclk);
        #1;
        txValid = 1'b0;
        check_eq("b2b_accept", txBusy, 1);
        check_frame(b, 0, 0);
    endtask

    // Hold reset a few cycles after an abort, then release and check recovery.
    task automatic recover_from_reset();
        repeat (5) begin
            @(negedge sysclk);
            check_eq("rst_hold_line", serialOut, 1);
            check_eq("rst_hold_done", txDone, 0);
            check_eq("rst_hold_ready", txReady, 0);
        end
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        check_eq("rel_ready", txReady, 1);
        check_eq("rel_line", serialOut, 1);
    endtask

    // Stimulus sequence and final report.
    initial begin
        logic [7:0] a;
        logic [7:0] b;
        reset   = 1'b1;
        txValid = 1'b0;
        txData  = 8'h00;
        #2;
        reset = 1'b0;

        // Reset held 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            check_eq("rst_line", serialOut, 1);
            check_eq("rst_ready", txReady, 0);
            check_eq("rst_busy", txBusy, 0);
            check_eq("rst_done", txDone, 0);
        end
        check_eq("rst_state", dbg_state, IDLE);
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        check_eq("first_ready", txReady, 1);
        check_eq("first_line", serialOut, 1);

        // Single frame 0x55.
        accept_byte(8'h55, 1'b0);
        check_frame(8'h55, 0, 0);

        // Back-to-back 0xAA then 0x08.
        send_pair(8'hAA, 8'h08);

        // Valid pulse mid-frame is ignored.
        accept_byte(8'h00, 1'b0);
        check_frame(8'h00, 80, 0);

        // Reset during data bit 4 of 0x3C, then a fresh 0x3C.
        accept_byte(8'h3C, 1'b0);
        check_frame(8'h3C, 0, 5 * CPB + 8);
        recover_from_reset();
        accept_byte(8'h3C, 1'b0);
        check_frame(8'h3C, 0, 0);

        // Reset during the start bit (line low).
        accept_byte(8'($urandom), 1'b0);
        check_frame(8'h00, 0, 5);
        recover_from_reset();

        // Parity cases (plain frames when parity is off).
        accept_byte(8'h08, 1'b0);
        check_frame(8'h08, 0, 0);
        accept_byte(8'h03, 1'b0);
        check_frame(8'h03, 0, 0);

        // Random traffic with random gaps and occasional back-to-back pairs.
        for (int n = 0; n < 16; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge sysclk);
            if ($urandom_range(0, 3) == 0) begin
                send_pair(a, b);
            end else begin
                accept_byte(a, 1'b0);
                check_frame(a, 0, 0);
            end
        end

        repeat (4) @(negedge sysclk);
        check_eq("final_line", serialOut, 1);
        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
